wb_burst_master: RTL
====================

# wb_burst_master

Parametrised Wishbone master that turns single-beat and burst commands from the bench or host logic into Wishbone classic and incrementing-burst cycles on the SDRAM controller's Wishbone slave port. It generalises the fixed 32-bit single-access driver port with:
- parametrised data/address width and maximum burst length;
- CTI burst signalling;
- write-data flow control;
- a read-data stream;
- a per-beat acknowledge timeout.

No command is accepted until the SDRAM controller reports `sdr_init_done`.

## Interface
Parameters:
- `dw`, 32: Wishbone data width; multiple of 8.
- `APP_AW`, 26: Wishbone byte-address width.
- `MAX_BURST`, 8: maximum beats per command; power of 2, ≥2. `LW = $clog2(MAX_BURST)`.
- `TIMEOUT`, 255: cycles a strobed beat may wait for `wb_ack_o` before abort; ≥1.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `sdr_init_done` in 1: SDRAM initialisation complete.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_addr` in APP_AW: start byte address; must be dw/8-aligned.
- `cmd_len` in LW: beats minus one.
- `cmd_sel` in dw/8: byte enables, applied to every beat.
- `wr_valid` in 1: write data available.
- `wr_data` in dw: write beat data.
- `wr_ready` out 1: write beat consumed (equals `wb_stb_i & wb_ack_o & wb_we_i`).
- `rd_valid` out 1: read beat valid.
- `rd_data` out dw: read beat data.
- `rd_last` out 1: final beat of the command.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` out 1: Wishbone master controls.
- `wb_addr_i` out APP_AW: Wishbone address.
- `wb_dat_i` out dw: Wishbone write data.
- `wb_sel_i` out dw/8: Wishbone byte enables.
- `wb_cti_i` out 3: Wishbone cycle type identifier.
- `wb_ack_o` in 1: slave acknowledge.
- `wb_dat_o` in dw: slave read data.
- `busy` out 1: command in progress.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, XFER, ABORT.
- **IDLE**
  - `cmd_ready = sdr_init_done`.
  - On handshake, latch we/addr/len/sel; beat counter ← 0; go to XFER.
- **XFER**
  - `wb_cyc_i = 1` throughout.
  - `wb_addr_i = start + beat*(dw/8)`, modulo 2^APP_AW; wraps silently.
  - `wb_stb_i = 1` for reads; for writes, `wb_stb_i = wr_valid`.
  - While the write strobe is low the cycle holds as a master wait state, and the timeout counter is held at 0.
  - `wb_dat_i = wr_data` combinationally.
  - `wb_sel_i = latched sel`; `wb_we_i = latched we`.
- **CTI**
  - Single beat (len = 0): 3'b000.
  - Burst, beats 0..len-1: 3'b010.
  - Burst, beat len: 3'b111.
- **Beat completion and exit**
  - A beat completes on `wb_stb_i & wb_ack_o`; beat counter increments.
  - Completing beat len returns to IDLE on the next edge; `cyc`/`stb` drop there.
- **Read data**
  - `rd_valid`, `rd_data`, `rd_last` are registered from `wb_ack_o & ~we`, `wb_dat_o`, and (beat == len).
  - Valid exactly one cycle after the ack; there is no backpressure.
- **Timeout**
  - Counter runs while `wb_stb_i & ~wb_ack_o`; clears on ack.
  - Reaching TIMEOUT enters ABORT.
  - ABORT (1 cycle): `cyc` = `stb` = 0, `err` = 1, remaining beats discarded; then IDLE.
- **Other rules**
  - `busy = (state != IDLE)`.
  - `sdr_init_done` falling mid-command does not abort the command; only new commands are blocked.

## Timing
- Reset, one edge with `wb_rst_i` high:
  - State → IDLE.
  - `wb_cyc_i`, `wb_stb_i`, `wb_we_i`, `rd_valid`, `rd_last`, `err`, `busy`, `cmd_ready` = 0.
  - `wb_addr_i`, `wb_sel_i`, `rd_data` = 0; `wb_cti_i` = 3'b000.
  - Reset mid-cycle drops `cyc` at that edge; no `err` is raised.
- Command accepted at edge N → `cyc`/`stb` high from cycle N+1.
- Zero-wait-state slave (ack in the same cycle as stb): a burst of L beats occupies cycles N+1..N+L.
- `cmd_ready` is high again in cycle N+L+1, giving one idle cycle between back-to-back commands.
- Read latency: ack cycle + 1 → `rd_valid`.
- Timeout: stb asserted at cycle S with no ack → ABORT entered at S+TIMEOUT; `err` high in that cycle; IDLE at S+TIMEOUT+1.
- An ack in the same cycle the counter reaches TIMEOUT wins: the beat completes and there is no abort.
- An ack while `wb_stb_i = 0` is ignored.

## Test plan
- **Gating:** `sdr_init_done` = 0, `cmd_valid` = 1 for 20 cycles → `cmd_ready` = 0, no `cyc`; raise `init_done` → accept next cycle.
- **Single write:** addr 0x100, len 0, sel 4'hF, data 0xDEADBEEF, ack on first stb → one beat, `cti` 000, `wb_dat_i` 0xDEADBEEF, `wr_ready` one pulse.
- **8-beat read:** addr 0x3FFFFF0 (APP_AW = 26), ack every cycle → `cti` 010×7 then 111.
  - Addresses 0x3FFFFF0, 0x3FFFFF4, 0x3FFFFF8, 0x3FFFFFC, 0x0000000, … (wrap).
  - Eight `rd_valid` pulses one cycle after each ack; `rd_last` on the 8th.
- **Write stall:** 4-beat write, `wr_valid` low for 3 cycles after beat 1 with TIMEOUT = 2 → `stb` low during the stall, `cyc` held, no `err`, four beats total.
- **Timeout:** 4-beat read, slave never acks, TIMEOUT = 5 → `err` pulse 5 cycles after first stb, `cyc` low, `busy` low next cycle, `cmd_ready` high.
- **Reset mid-burst:** `wb_rst_i` asserted during beat 3 of 8 → all outputs at reset values next edge, `err` = 0; a new command afterwards completes normally.

Source files
------------

// File: rtl/wb_burst_master.sv
// Wishbone master that turns single-beat and burst commands into classic and
// incrementing-burst cycles, with a per-beat acknowledge timeout.
module wb_burst_master #(
    parameter int dw        = 32,
    parameter int APP_AW    = 26,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 255,
    localparam int LW       = $clog2(MAX_BURST)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LW-1:0]     cmd_len,
    input  logic [dw/8-1:0]   cmd_sel,
    input  logic              wr_valid,
    input  logic [dw-1:0]     wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    output logic              rd_last,
    output logic              wb_cyc_i,
    output logic              wb_stb_i,
    output logic              wb_we_i,
    output logic [APP_AW-1:0] wb_addr_i,
    output logic [dw-1:0]     wb_dat_i,
    output logic [dw/8-1:0]   wb_sel_i,
    output logic [2:0]        wb_cti_i,
    input  logic              wb_ack_o,
    input  logic [dw-1:0]     wb_dat_o,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [APP_AW-1:0] STEP = APP_AW'(dw / 8);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ABORT
    } state_t;

    state_t            state;
    logic              we_q;
    logic [APP_AW-1:0] addr_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     beat;
    logic [dw/8-1:0]   sel_q;
    logic [TW-1:0]     tcnt;
    logic              last;
    logic              beat_done;

    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && sdr_init_done && !wb_rst_i;
    assign wb_cyc_i  = (state == XFER);
    assign wb_stb_i  = wb_cyc_i && (!we_q || wr_valid);
    assign wb_we_i   = we_q;
    assign wb_addr_i = addr_q;
    assign wb_sel_i  = sel_q;
    assign wb_dat_i  = wr_data;
    assign last      = (beat == len_q);
    assign beat_done = wb_stb_i && wb_ack_o;
    assign wr_ready  = beat_done && we_q;

    always_comb begin
        wb_cti_i = 3'b000;
        if (wb_cyc_i && len_q != '0)
            wb_cti_i = last ? 3'b111 : 3'b010;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat     <= '0;
            sel_q    <= '0;
            tcnt     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        we_q   <= cmd_we;
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        sel_q  <= cmd_sel;
                        beat   <= '0;
                        tcnt   <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (beat_done) begin
                        tcnt <= '0;
                        if (!we_q) begin
                            rd_valid <= 1'b1;
                            rd_data  <= wb_dat_o;
                            rd_last  <= last;
                        end
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            beat   <= beat + 1'b1;
                            addr_q <= addr_q + STEP;
                        end
                    end else if (wb_stb_i) begin
                        // ack on the final count still wins via the branch above
                        if (tcnt == TLAST) begin
                            tcnt  <= '0;
                            err   <= 1'b1;
                            state <= ABORT;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        tcnt <= '0;
                    end
                end
                ABORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
